// File: rtl/iaxi_auto_load_master_pkg.sv
// Shared widths and AXI encodings for the ITCM auto-load read master.
package iaxi_auto_load_master_pkg;

  localparam int unsigned ADDR_WIDTH     = 32;
  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned AXI_ADDR_WIDTH = 32;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [2:0] AXI_PROT_INSTR = 3'b100;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

  // SLVERR (2'b10) and DECERR (2'b11) both carry bit 1 set.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/iaxi_auto_load_master.sv
// Single-beat AXI4 read master for ITCM auto-load: one word per request,
// bounded retry on error responses, ERR_DATA substituted when retries run out.
module iaxi_auto_load_master
  import iaxi_auto_load_master_pkg::*;
#(
  parameter int unsigned           RETRY_MAX = 2,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA  = 32'h0000_0013
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      itcm_access_AXI,
  input  logic [ADDR_WIDTH-1:0]     itcm_auto_load_addr,
  output logic                      IAXI_ready,
  output logic [DATA_WIDTH-1:0]     IAXI_read_data,
  output logic                      IAXI_read_data_valid,
  output logic                      IAXI_load_err,
  output logic                      IAXI_ARVALID,
  input  logic                      IAXI_ARREADY,
  output logic [AXI_ADDR_WIDTH-1:0] IAXI_ARADDR,
  output logic [7:0]                IAXI_ARLEN,
  output logic [2:0]                IAXI_ARSIZE,
  output logic [1:0]                IAXI_ARBURST,
  output logic [2:0]                IAXI_ARPROT,
  input  logic                      IAXI_RVALID,
  output logic                      IAXI_RREADY,
  input  logic [DATA_WIDTH-1:0]     IAXI_RDATA,
  input  logic [1:0]                IAXI_RRESP,
  input  logic                      IAXI_RLAST
);

  localparam int unsigned CntW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

  typedef enum logic [1:0] {StIdle, StAr, StR} state_e;

  state_e                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic                      pulse_q, pulse_d;
  logic                      load_err_q, load_err_d;
  logic [CntW-1:0]           retry_q, retry_d;

  // RLAST is redundant with ARLEN=0; address byte offset is dropped.
  logic unused_inputs;
  assign unused_inputs = ^{IAXI_RLAST, itcm_auto_load_addr[1:0], IAXI_RRESP[0]};

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      araddr_q   <= '0;
      rdata_q    <= '0;
      pulse_q    <= 1'b0;
      load_err_q <= 1'b0;
      retry_q    <= '0;
    end else begin
      state_q    <= state_d;
      araddr_q   <= araddr_d;
      rdata_q    <= rdata_d;
      pulse_q    <= pulse_d;
      load_err_q <= load_err_d;
      retry_q    <= retry_d;
    end
  end

  // Next-state: IDLE -> AR -> R, looping back to AR on a retryable error.
  always_comb begin
    state_d    = state_q;
    araddr_d   = araddr_q;
    rdata_d    = rdata_q;
    pulse_d    = 1'b0;
    load_err_d = load_err_q;
    retry_d    = retry_q;
    case (state_q)
      StIdle: begin
        if (itcm_access_AXI) begin
          araddr_d = {itcm_auto_load_addr[AXI_ADDR_WIDTH-1:2], 2'b00};
          state_d  = StAr;
        end
      end
      StAr: begin
        if (IAXI_ARREADY) state_d = StR;
      end
      StR: begin
        if (IAXI_RVALID) begin
          if (!resp_is_err(IAXI_RRESP)) begin
            rdata_d = IAXI_RDATA;
            pulse_d = 1'b1;
            retry_d = '0;
            state_d = StIdle;
          end else if (retry_q < CntW'(RETRY_MAX)) begin
            retry_d = retry_q + CntW'(1);
            state_d = StAr;
          end else begin
            rdata_d    = ERR_DATA;
            pulse_d    = 1'b1;
            load_err_d = 1'b1;
            retry_d    = '0;
            state_d    = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign IAXI_ready           = (state_q == StIdle);
  assign IAXI_ARVALID         = (state_q == StAr);
  assign IAXI_RREADY          = (state_q == StR);
  assign IAXI_ARADDR          = araddr_q;
  assign IAXI_read_data       = rdata_q;
  assign IAXI_read_data_valid = pulse_q;
  assign IAXI_load_err        = load_err_q;
  assign IAXI_ARLEN           = AXI_LEN_SINGLE;
  assign IAXI_ARSIZE          = AXI_SIZE_4B;
  assign IAXI_ARBURST         = AXI_BURST_INCR;
  assign IAXI_ARPROT          = AXI_PROT_INSTR;

endmodule

// File: tb/tb_iaxi_auto_load_master.sv
// Bench for iaxi_auto_load_master: directed and randomized reads against a
// transaction-level model (attempt count, returned word, sticky error flag).
module tb_iaxi_auto_load_master;

  localparam int unsigned RetryMax = 2;
  localparam logic [31:0] ErrData  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        itcm_access_AXI = 1'b0;
  logic [31:0] itcm_auto_load_addr = '0;
  logic        IAXI_ready;
  logic [31:0] IAXI_read_data;
  logic        IAXI_read_data_valid;
  logic        IAXI_load_err;
  logic        IAXI_ARVALID;
  logic        IAXI_ARREADY = 1'b0;
  logic [31:0] IAXI_ARADDR;
  logic [7:0]  IAXI_ARLEN;
  logic [2:0]  IAXI_ARSIZE;
  logic [1:0]  IAXI_ARBURST;
  logic [2:0]  IAXI_ARPROT;
  logic        IAXI_RVALID = 1'b0;
  logic        IAXI_RREADY;
  logic [31:0] IAXI_RDATA = '0;
  logic [1:0]  IAXI_RRESP = '0;
  logic        IAXI_RLAST = 1'b0;

  int checks   = 0;
  int failures = 0;

  // Model state: last word delivered and sticky error flag.
  logic [31:0] exp_rdata = '0;
  logic        exp_err   = 1'b0;

  always #5 clk = ~clk;

  iaxi_auto_load_master #(
    .RETRY_MAX (RetryMax),
    .ERR_DATA  (ErrData)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .itcm_access_AXI      (itcm_access_AXI),
    .itcm_auto_load_addr  (itcm_auto_load_addr),
    .IAXI_ready           (IAXI_ready),
    .IAXI_read_data       (IAXI_read_data),
    .IAXI_read_data_valid (IAXI_read_data_valid),
    .IAXI_load_err        (IAXI_load_err),
    .IAXI_ARVALID         (IAXI_ARVALID),
    .IAXI_ARREADY         (IAXI_ARREADY),
    .IAXI_ARADDR          (IAXI_ARADDR),
    .IAXI_ARLEN           (IAXI_ARLEN),
    .IAXI_ARSIZE          (IAXI_ARSIZE),
    .IAXI_ARBURST         (IAXI_ARBURST),
    .IAXI_ARPROT          (IAXI_ARPROT),
    .IAXI_RVALID          (IAXI_RVALID),
    .IAXI_RREADY          (IAXI_RREADY),
    .IAXI_RDATA           (IAXI_RDATA),
    .IAXI_RRESP           (IAXI_RRESP),
    .IAXI_RLAST           (IAXI_RLAST)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One word read. Called at a negedge with the master idle; returns at the
  // negedge of the valid pulse, so the next call lands back-to-back.
  task automatic transact(input logic [31:0] addr, input int ar_wait, input int r_wait,
                          input int nerr, input logic [31:0] good);
    int          attempts;
    logic [31:0] exp_addr;
    logic        gives_up;
    gives_up = (nerr > int'(RetryMax));
    attempts = (gives_up ? int'(RetryMax) : nerr) + 1;
    exp_addr = addr & 32'hFFFF_FFFC;

    chk("ready_before_req", {31'd0, IAXI_ready}, 32'd1);
    itcm_access_AXI     = 1'b1;
    itcm_auto_load_addr = addr;
    cycle();
    for (int a = 0; a < attempts; a++) begin
      for (int w = 0; w <= ar_wait; w++) begin
        chk("ar_arvalid", {31'd0, IAXI_ARVALID}, 32'd1);
        chk("ar_araddr", IAXI_ARADDR, exp_addr);
        chk("ar_busy", {29'd0, IAXI_ready, IAXI_RREADY, IAXI_read_data_valid}, 32'd0);
        // Traffic the master must ignore while busy.
        itcm_access_AXI     = 1'($urandom_range(0, 1));
        itcm_auto_load_addr = $urandom;
        IAXI_RVALID         = 1'($urandom_range(0, 1));
        IAXI_RRESP          = 2'($urandom_range(0, 3));
        IAXI_RDATA          = $urandom;
        IAXI_ARREADY        = (w == ar_wait);
        cycle();
      end
      IAXI_ARREADY = 1'b0;
      for (int w = 0; w <= r_wait; w++) begin
        chk("r_rready", {31'd0, IAXI_RREADY}, 32'd1);
        chk("r_busy", {29'd0, IAXI_ready, IAXI_ARVALID, IAXI_read_data_valid}, 32'd0);
        itcm_access_AXI     = 1'($urandom_range(0, 1));
        itcm_auto_load_addr = $urandom;
        IAXI_RVALID         = (w == r_wait);
        IAXI_RLAST          = 1'b1;
        IAXI_RDATA          = (a == nerr) ? good : $urandom;
        IAXI_RRESP          = (a < nerr) ? {1'b1, 1'($urandom_range(0, 1))} : 2'b00;
        cycle();
      end
      IAXI_RVALID = 1'b0;
      IAXI_RRESP  = 2'b00;
    end
    itcm_access_AXI = 1'b0;
    exp_rdata = gives_up ? ErrData : good;
    exp_err   = exp_err | gives_up;
    chk("pulse_valid", {31'd0, IAXI_read_data_valid}, 32'd1);
    chk("pulse_data", IAXI_read_data, exp_rdata);
    chk("pulse_ready", {31'd0, IAXI_ready}, 32'd1);
    chk("pulse_load_err", {31'd0, IAXI_load_err}, {31'd0, exp_err});
    chk("pulse_quiet", {30'd0, IAXI_ARVALID, IAXI_RREADY}, 32'd0);
  endtask

  // Idle cycles: no pulse, data held, stray RVALID ignored.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      IAXI_RVALID = 1'($urandom_range(0, 1));
      IAXI_RDATA  = $urandom;
      cycle();
      chk("idle_quiet", {29'd0, IAXI_read_data_valid, IAXI_ARVALID, IAXI_RREADY}, 32'd0);
      chk("idle_ready", {31'd0, IAXI_ready}, 32'd1);
      chk("idle_hold", IAXI_read_data, exp_rdata);
      chk("idle_load_err", {31'd0, IAXI_load_err}, {31'd0, exp_err});
    end
    IAXI_RVALID = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_ready", {31'd0, IAXI_ready}, 32'd1);
    chk("rst_outs", {28'd0, IAXI_ARVALID, IAXI_RREADY, IAXI_read_data_valid, IAXI_load_err},
        32'd0);
    chk("rst_data", IAXI_read_data, 32'd0);
    chk("arlen", {24'd0, IAXI_ARLEN}, 32'd0);
    chk("arsize", {29'd0, IAXI_ARSIZE}, 32'd2);
    chk("arburst", {30'd0, IAXI_ARBURST}, 32'd1);
    chk("arprot", {29'd0, IAXI_ARPROT}, 32'd4);
    @(negedge clk);
    rst = 1'b0;
    idle(1);

    // Minimum-latency read with unaligned address.
    transact(32'h0000_0006, 0, 0, 0, 32'hDEAD_BEEF);
    idle(2);
    // AR stall of five cycles.
    transact($urandom, 5, 0, 0, $urandom);
    idle(1);
    // Two errors then OKAY: recovered, no error flag.
    transact($urandom, 0, 1, 2, $urandom);
    idle(1);
    // Three errors: retries exhausted, ERR_DATA and sticky flag.
    transact($urandom, 1, 0, 3, $urandom);
    idle(3);
    // Back-to-back words.
    for (int k = 0; k < 4; k++) transact(32'(k * 4), 0, 0, 0, $urandom);
    idle(1);

    // Randomized traffic.
    for (int i = 0; i < 25; i++) begin
      transact($urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4),
               $urandom);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end

    // Asynchronous reset while waiting in R.
    itcm_access_AXI     = 1'b1;
    itcm_auto_load_addr = 32'h0000_1234;
    cycle();
    itcm_access_AXI = 1'b0;
    IAXI_ARREADY    = 1'b1;
    cycle();
    IAXI_ARREADY = 1'b0;
    chk("pre_rst_rready", {31'd0, IAXI_RREADY}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    exp_rdata = '0;
    exp_err   = 1'b0;
    chk("arst_ready", {31'd0, IAXI_ready}, 32'd1);
    chk("arst_outs", {28'd0, IAXI_ARVALID, IAXI_RREADY, IAXI_read_data_valid, IAXI_load_err},
        32'd0);
    chk("arst_data", IAXI_read_data, 32'd0);
    chk("arst_araddr", IAXI_ARADDR, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    transact(32'h0000_0040, 0, 0, 0, 32'hCAFE_F00D);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
